// File: rtl/load_store_unit.sv
// Load/store unit: FSM (IDLE/RD/WR/RESP) bridging a pipeline request to a word-indexed data memory.
// Optional LSU_RMW_EN: sub-word stores become read-modify-write of the full word.
module load_store_unit #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        memRead,
   output logic        memWrite,
   output logic [2:0]  memType,
   output logic [31:0] memAddr,
   output logic [31:0] memWrData,
   input  logic [31:0] memDataOut
);

   localparam int DATA_W = 32;
`ifdef LSU_RMW_EN
   localparam logic RMW = 1'b1;
`else
   localparam logic RMW = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t              state, state_nx;
   logic [1:0]          cnt;
   logic                is_store_p0;
   logic [2:0]          funct3_p0;
   logic [DATA_W-1:0]   addr_p0, wdata_p0, word_p1;
   logic                sub_rmw;

   function automatic logic req_illegal(input logic st, input logic [2:0] f3, input logic [1:0] a);
      logic bad;
      case (f3)
         3'b000:  bad = 1'b0;
         3'b001:  bad = a[0];
         3'b010:  bad = (a != 2'b00);
         3'b100:  bad = st;
         3'b101:  bad = st | a[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                      input logic [DATA_W-1:0] word);
      logic signed [7:0]        b;
      logic signed [15:0]       h;
      logic signed [DATA_W-1:0] ext;
      b = word[{a, 3'b000} +: 8];
      h = word[{a[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  ext = b;
         3'b001:  ext = h;
         3'b100:  ext = {24'd0, b};
         3'b101:  ext = {16'd0, h};
         default: ext = word;
      endcase
      return ext;
   endfunction

   function automatic logic [DATA_W-1:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                                     input logic [DATA_W-1:0] word,
                                                     input logic [DATA_W-1:0] wd);
      logic [DATA_W-1:0] res;
      res = word;
      if (f3[0] == 1'b0)
         res[{a, 3'b000} +: 8] = wd[7:0];
      else
         res[{a[1], 4'b0000} +: 16] = wd[15:0];
      return res;
   endfunction

   assign sub_rmw = RMW && (funct3_p0 != 3'b010);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_illegal(req_is_store, req_funct3, req_addr[1:0]))
                  state_nx = RESP;
               else if (!req_is_store || (RMW && req_funct3 != 3'b010))
                  state_nx = RD;
               else
                  state_nx = WR;
            end
         end
         RD:      if (cnt == 2'd0) state_nx = is_store_p0 ? WR : RESP;
         WR:      state_nx = RESP;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
      memRead   = (state == RD);
      memWrite  = (state == WR);
      memType   = 3'b000;
      memAddr   = '0;
      memWrData = '0;
      if (state == RD || state == WR)
         memAddr = {2'b00, addr_p0[31:2]};
      if (state == RD)
         memType = 3'b010;
      if (state == WR) begin
         memType   = RMW ? 3'b010 : funct3_p0;
         memWrData = sub_rmw ? store_merge(funct3_p0, addr_p0[1:0], word_p1, wdata_p0) : wdata_p0;
      end
   end

   // control: state, read-latency counter, held response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cnt <= 2'(RD_LAT - 1);
                  if (req_illegal(req_is_store, req_funct3, req_addr[1:0])) begin
                     rsp_rdata <= '0;
                     rsp_err   <= 1'b1;
                  end
               end
            end
            RD: begin
               if (cnt != 2'd0)
                  cnt <= cnt - 2'd1;
               else if (!is_store_p0) begin
                  rsp_rdata <= load_extract(funct3_p0, addr_p0[1:0], memDataOut);
                  rsp_err   <= 1'b0;
               end
            end
            WR: begin
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // request capture (p0) and last-RD-cycle word capture (p1)
   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         is_store_p0 <= req_is_store;
         funct3_p0   <= req_funct3;
         addr_p0     <= req_addr;
         wdata_p0    <= req_wdata;
      end
      if (state == RD && cnt == 2'd0)
         word_p1 <= memDataOut;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL provide parameter RD_LAT, default 1, range 1-4: memRead cycles held before read data is captured.
REQ-002 SHALL provide clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide rst_n  input  1  reset: synchronous, active-low; one clock.
REQ-004 SHALL provide req_valid  input  1  pipeline request present.
REQ-005 SHALL provide req_ready  output  1  unit idle; a request is accepted when req_valid and req_ready are both 1 at a clock edge.
REQ-006 SHALL provide req_is_store  input  1  1 = store, 0 = load.
REQ-007 SHALL provide req_funct3  input  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL provide req_addr  input  32  byte address.
REQ-009 SHALL provide req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL provide rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL provide rsp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL provide rsp_err  output  1  misaligned or illegal request, qualified by rsp_valid.
REQ-013 SHALL provide memRead, memWrite  output  1 each  data-memory strobes.
REQ-014 SHALL provide memType  output  3  data-memory width code.
REQ-015 SHALL provide memAddr  output  32  word index, {2'b00, addr[31:2]}.
REQ-016 SHALL provide memWrData  output  32  write word.
REQ-017 SHALL provide memDataOut  input  32  combinational read word.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 On accept, SHALL latch is_store, funct3, addr and wdata; a request is accepted in cycle T.
REQ-020 SHALL flag an error when H/HU has addr[0]=1, W has addr[1:0]!=0, funct3 is 011/110/111, or a store uses 100/101; an error goes IDLE->RESP with no memory strobe, so rsp_valid asserts at T+1.
REQ-021 Load: SHALL go IDLE->RD; RD holds memRead=1, memType=010 for RD_LAT cycles, counted by a down-counter; memDataOut is captured on the last RD cycle; then RESP, so rsp_valid asserts at T+RD_LAT+1.
REQ-022 Load extraction: lane = addr[1:0]; LB/LBU select byte lane*8, LH/LHU select halfword addr[1]*16; B/H are sign-extended, BU/HU zero-extended, W is passed through.
REQ-023 SW: SHALL go IDLE->WR; WR asserts memWrite=1, memType=010, memWrData=wdata for one cycle; then RESP at T+2.
REQ-024 SHALL never assert memRead and memWrite together; both SHALL be 0 in IDLE and RESP.
REQ-025 memAddr SHALL be held constant from the first RD/WR cycle to the last RD/WR cycle of a request.
REQ-026 RESP SHALL last exactly one cycle, then return to IDLE; rsp_valid has no back-pressure, so a new request may be accepted the cycle after RESP.
REQ-027 rsp_rdata and rsp_err SHALL hold their values until the next RESP.
REQ-028 req_valid arriving outside IDLE SHALL be ignored (not queued).

Reset
REQ-029 While rst_n=0 at an edge, SHALL force IDLE, clear the RD counter, and drive req_ready=1 plus all other outputs 0, including memType=000.
REQ-030 Reset mid-RD or mid-WR SHALL abort the request without rsp_valid; no memWrite SHALL occur in the cycle after reset.

Configuration
REQ-031 With LSU_RMW_EN defined, SB/SH SHALL do read-modify-write:
- RD phase as for loads (REQ-021).
- WR phase then writes the captured word with the target byte/halfword lane replaced by wdata, using memType=010.
- RESP follows at T+RD_LAT+2.
REQ-032 Without LSU_RMW_EN, SB/SH SHALL go IDLE->WR with memType=req_funct3 and memWrData=req_wdata unshifted, i.e. a direct sub-word write; RESP follows at T+2.

Verification
REQ-033 Reset: rst_n=0 for 2 cycles mid-load -> no rsp_valid; req_ready=1; memRead=0.
REQ-034 LB at addr 0x103, word[0x40]=0x80FF1234, RD_LAT=1 -> memAddr=0x40, memRead for 1 cycle, rsp_valid at T+2, rsp_rdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-035 LH at addr 0x101 -> rsp_err=1 at T+1, rsp_rdata=0, memRead/memWrite never 1.
REQ-036 SB wdata=0xAB at addr 0x202, word[0x80]=0x11223344, LSU_RMW_EN on, RD_LAT=2 -> read cycles T+1..T+2, write 0x11AB3344 at T+3, rsp_valid at T+4.
REQ-037 SW 0xDEADBEEF at addr 0x10 -> memWrite=1 at T+1, memAddr=0x4, memType=010; rsp_valid at T+2; a back-to-back LW from 0x10 returns 0xDEADBEEF.
REQ-038 Illegal: store with funct3=100 -> rsp_err=1 with no strobe; req_valid held during RD is ignored and no second response is produced.
